// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - direct-mapped instruction cache with line-refill FSM
//
// Purpose:
//   Direct-mapped I-cache for the IF stage. A fetch lookup is served in
//   the same cycle it is presented. A miss raises o_ICache_Miss, which the
//   stall logic uses to hold the PC and flush IFID. The controller then
//   refills the whole line one word at a time over a req/ack memory port.
//   o_ICache_Miss stays high until the refilled line can be read.
//
// Optional feature (macro ICACHE_STATS_EN):
//   When the macro is defined, the block gains o_Hit_Count and o_Miss_Count.
//   These are saturating 32-bit counters that are cleared by reset.
//
// Ports:
//   i_Clk          clock; all state updates happen on the rising edge
//   i_Reset        synchronous, active-high reset
//   i_PC           fetch byte address; bits [1:0] are ignored
//   i_Fetch_En     a fetch request is valid this cycle
//   i_Invalidate   one-cycle pulse that invalidates every line
//   o_Instr        instruction word for i_PC; meaningful only on a hit
//   o_ICache_Miss  high while the fetch cannot be served
//   o_Mem_Req      memory read request
//   o_Mem_Addr     word-aligned memory read address
//   o_Hit_Count    (ICACHE_STATS_EN only) count of IDLE cycles that hit
//   o_Miss_Count   (ICACHE_STATS_EN only) count of refills started
//   i_Mem_Ack      memory read data is valid this cycle
//   i_Mem_Data     memory read data

module icache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [ADDR_W-1:0] i_PC,
    input  logic              i_Fetch_En,
    input  logic              i_Invalidate,
    output logic [DATA_W-1:0] o_Instr,
    output logic              o_ICache_Miss,
    output logic              o_Mem_Req,
    output logic [ADDR_W-1:0] o_Mem_Addr,
`ifdef ICACHE_STATS_EN
    output logic [31:0]       o_Hit_Count,
    output logic [31:0]       o_Miss_Count,
`endif
    input  logic              i_Mem_Ack,
    input  logic [DATA_W-1:0] i_Mem_Data
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LOW_W  = 2 + WORD_W;          // word + byte offset bits
    localparam int TAG_W  = ADDR_W - LOW_W - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REFILL    = 2'd1,
        ST_FILL_DONE = 2'd2,
        ST_INVAL     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [WORD_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]      sweep_q, sweep_d;
    logic                  pend_q, pend_d;

    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [DATA_W-1:0]     data_mem [NUM_LINES*LINE_WORDS];

    // Fetch address decode
    logic [WORD_W-1:0]     pc_word;
    logic [IDX_W-1:0]      pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic                  hit;
    logic                  unused_pc_offset;

    assign pc_word          = i_PC[2 +: WORD_W];
    assign pc_idx           = i_PC[LOW_W +: IDX_W];
    assign pc_tag           = i_PC[ADDR_W-1 -: TAG_W];
    assign unused_pc_offset = ^i_PC[1:0];

    assign hit     = i_Fetch_En & valid_q[pc_idx] & (tag_mem[pc_idx] == pc_tag);
    assign o_Instr = data_mem[{pc_idx, pc_word}];

    // Refill line decode, taken from the latched base address
    logic [IDX_W-1:0]      base_idx;
    logic [TAG_W-1:0]      base_tag;
    logic                  last_word;
    logic                  start_refill;
    logic                  word_wr;
    logic                  fill_last;

    assign base_idx     = base_q[LOW_W +: IDX_W];
    assign base_tag     = base_q[ADDR_W-1 -: TAG_W];
    assign last_word    = (cnt_q == WORD_W'(LINE_WORDS - 1));
    assign start_refill = (state_q == ST_IDLE) & ~i_Invalidate & i_Fetch_En & ~hit;
    assign word_wr      = (state_q == ST_REFILL) & i_Mem_Ack;
    assign fill_last    = word_wr & last_word;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            sweep_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
            pend_q  <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        sweep_d = sweep_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                // Invalidate wins over a simultaneous miss
                if (i_Invalidate) begin
                    state_d = ST_INVAL;
                    sweep_d = '0;
                end else if (i_Fetch_En && !hit) begin
                    state_d = ST_REFILL;
                    base_d  = {i_PC[ADDR_W-1:LOW_W], {LOW_W{1'b0}}};
                    cnt_d   = '0;
                end
            end
            ST_REFILL: begin
                // The refill is never aborted; a flush waits for it to finish
                if (i_Invalidate) begin
                    pend_d = 1'b1;
                end
                if (i_Mem_Ack) begin
                    cnt_d = cnt_q + WORD_W'(1);
                    if (last_word) begin
                        state_d = ST_FILL_DONE;
                    end
                end
            end
            ST_FILL_DONE: begin
                if (pend_q || i_Invalidate) begin
                    state_d = ST_INVAL;
                    sweep_d = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INVAL: begin
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == IDX_W'(NUM_LINES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_ICache_Miss = 1'b0;
        o_Mem_Req     = 1'b0;
        o_Mem_Addr    = '0;
        case (state_q)
            ST_IDLE: begin
                o_ICache_Miss = i_Fetch_En & ~hit;
            end
            ST_REFILL: begin
                o_ICache_Miss = 1'b1;
                // Gate with reset so the port is quiet in the reset cycle itself
                if (!i_Reset) begin
                    o_Mem_Req  = 1'b1;
                    o_Mem_Addr = base_q | {{(ADDR_W-LOW_W){1'b0}}, cnt_q, 2'b00};
                end
            end
            ST_FILL_DONE: begin
                o_ICache_Miss = 1'b1;
            end
            ST_INVAL: begin
                o_ICache_Miss = 1'b1;
            end
            default: begin
                o_ICache_Miss = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Valid bits. The line is dropped as soon as a refill claims it. A
    // partly written line therefore never pairs with a stale tag.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            valid_q <= '0;
        end else begin
            if (start_refill) begin
                valid_q[pc_idx] <= 1'b0;
            end
            if (fill_last) begin
                valid_q[base_idx] <= 1'b1;
            end
            if (state_q == ST_INVAL) begin
                valid_q[sweep_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays hold no reset; valid bits qualify them
    always_ff @(posedge i_Clk) begin
        if (word_wr && !i_Reset) begin
            data_mem[{base_idx, cnt_q}] <= i_Mem_Data;
            if (last_word) begin
                tag_mem[base_idx] <= base_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (start_refill && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign o_Hit_Count  = hit_cnt_q;
    assign o_Miss_Count = miss_cnt_q;
`endif

endmodule
